// File: rtl/idex_pipe_if.sv
// ID/EX boundary bundle: decoded ID-side fields, the registered EX-side copies,
// and the hazard/flush/counter outputs. The master drives ID inputs; the pipe is the slave.
interface idex_pipe_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0] ID_PC, ID_RegA, ID_RegB, ID_Imm12Ext, ID_DAddr9Ext;
    logic [4:0]            ID_Rn, ID_Rm, ID_Rd;
    logic                  ID_usesRm;
    logic [5:0]            ID_shamt;
    logic                  ID_RegWrite, ID_MemWrite, ID_MemToReg, ID_BrTaken;
    logic                  ID_read_enable, ID_NOOP, ID_shiftDirection;
    logic [1:0]            ID_ALUSrc, ID_ALUResult;
    logic [2:0]            ID_ALUOp;
    logic [3:0]            ID_xfer_size;
    logic                  EXMEM_BrTaken;

    logic [DATA_WIDTH-1:0] EX_PC, EX_RegA, EX_RegB, EX_Imm12Ext, EX_DAddr9Ext;
    logic [4:0]            EX_Rn, EX_Rm, EX_Rd;
    logic                  EX_usesRm;
    logic [5:0]            EX_shamt;
    logic                  EX_RegWrite, EX_MemWrite, EX_MemToReg, EX_BrTaken;
    logic                  EX_read_enable, EX_NOOP, EX_shiftDirection;
    logic [1:0]            EX_ALUSrc, EX_ALUResult;
    logic [2:0]            EX_ALUOp;
    logic [3:0]            EX_xfer_size;
    logic                  EX_valid;

    logic                  stall_IF, flush_IFID;
    logic [CNT_WIDTH-1:0]  stall_count, flush_count;

    modport master (
        output ID_PC, ID_RegA, ID_RegB, ID_Imm12Ext, ID_DAddr9Ext,
               ID_Rn, ID_Rm, ID_Rd, ID_usesRm, ID_shamt,
               ID_RegWrite, ID_MemWrite, ID_MemToReg, ID_BrTaken,
               ID_read_enable, ID_NOOP, ID_shiftDirection,
               ID_ALUSrc, ID_ALUResult, ID_ALUOp, ID_xfer_size, EXMEM_BrTaken,
        input  EX_PC, EX_RegA, EX_RegB, EX_Imm12Ext, EX_DAddr9Ext,
               EX_Rn, EX_Rm, EX_Rd, EX_usesRm, EX_shamt,
               EX_RegWrite, EX_MemWrite, EX_MemToReg, EX_BrTaken,
               EX_read_enable, EX_NOOP, EX_shiftDirection,
               EX_ALUSrc, EX_ALUResult, EX_ALUOp, EX_xfer_size, EX_valid,
               stall_IF, flush_IFID, stall_count, flush_count
    );

    modport slave (
        input  ID_PC, ID_RegA, ID_RegB, ID_Imm12Ext, ID_DAddr9Ext,
               ID_Rn, ID_Rm, ID_Rd, ID_usesRm, ID_shamt,
               ID_RegWrite, ID_MemWrite, ID_MemToReg, ID_BrTaken,
               ID_read_enable, ID_NOOP, ID_shiftDirection,
               ID_ALUSrc, ID_ALUResult, ID_ALUOp, ID_xfer_size, EXMEM_BrTaken,
        output EX_PC, EX_RegA, EX_RegB, EX_Imm12Ext, EX_DAddr9Ext,
               EX_Rn, EX_Rm, EX_Rd, EX_usesRm, EX_shamt,
               EX_RegWrite, EX_MemWrite, EX_MemToReg, EX_BrTaken,
               EX_read_enable, EX_NOOP, EX_shiftDirection,
               EX_ALUSrc, EX_ALUResult, EX_ALUOp, EX_xfer_size, EX_valid,
               stall_IF, flush_IFID, stall_count, flush_count
    );
endinterface

// File: rtl/idex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or taken-branch flush, and saturating stall/flush cycle counters.
module idex_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input logic         clk,
    input logic         reset,
    idex_pipe_if.slave  bus
);
    localparam logic [4:0]           XZR     = 5'd31;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic hazard;
    logic flush;
    logic load;

    // A load in EX only blocks the consumer when it really writes a register
    // the ID instruction reads; XZR and unused Rm never count.
    assign hazard = bus.EX_valid & bus.EX_read_enable & (bus.EX_Rd != XZR)
                  & ~bus.ID_NOOP
                  & ((bus.EX_Rd == bus.ID_Rn) | (bus.ID_usesRm & (bus.EX_Rd == bus.ID_Rm)));
    assign flush  = bus.EXMEM_BrTaken;
    assign load   = ~flush & ~hazard;

    // The stalled instruction is discarded by a flush, so the flush wins.
    assign bus.stall_IF   = hazard & ~flush;
    assign bus.flush_IFID = flush;

    always_ff @(posedge clk) begin
        if (reset || !load) begin
            bus.EX_PC             <= '0;
            bus.EX_RegA           <= '0;
            bus.EX_RegB           <= '0;
            bus.EX_Imm12Ext       <= '0;
            bus.EX_DAddr9Ext      <= '0;
            bus.EX_Rn             <= '0;
            bus.EX_Rm             <= '0;
            bus.EX_Rd             <= '0;
            bus.EX_usesRm         <= 1'b0;
            bus.EX_shamt          <= '0;
            bus.EX_RegWrite       <= 1'b0;
            bus.EX_MemWrite       <= 1'b0;
            bus.EX_MemToReg       <= 1'b0;
            bus.EX_BrTaken        <= 1'b0;
            bus.EX_read_enable    <= 1'b0;
            bus.EX_NOOP           <= 1'b1;
            bus.EX_shiftDirection <= 1'b0;
            bus.EX_ALUSrc         <= '0;
            bus.EX_ALUResult      <= '0;
            bus.EX_ALUOp          <= '0;
            bus.EX_xfer_size      <= '0;
            bus.EX_valid          <= 1'b0;
        end else begin
            bus.EX_PC             <= bus.ID_PC;
            bus.EX_RegA           <= bus.ID_RegA;
            bus.EX_RegB           <= bus.ID_RegB;
            bus.EX_Imm12Ext       <= bus.ID_Imm12Ext;
            bus.EX_DAddr9Ext      <= bus.ID_DAddr9Ext;
            bus.EX_Rn             <= bus.ID_Rn;
            bus.EX_Rm             <= bus.ID_Rm;
            bus.EX_Rd             <= bus.ID_Rd;
            bus.EX_usesRm         <= bus.ID_usesRm;
            bus.EX_shamt          <= bus.ID_shamt;
            bus.EX_RegWrite       <= bus.ID_RegWrite;
            bus.EX_MemWrite       <= bus.ID_MemWrite;
            bus.EX_MemToReg       <= bus.ID_MemToReg;
            bus.EX_BrTaken        <= bus.ID_BrTaken;
            bus.EX_read_enable    <= bus.ID_read_enable;
            bus.EX_NOOP           <= bus.ID_NOOP;
            bus.EX_shiftDirection <= bus.ID_shiftDirection;
            bus.EX_ALUSrc         <= bus.ID_ALUSrc;
            bus.EX_ALUResult      <= bus.ID_ALUResult;
            bus.EX_ALUOp          <= bus.ID_ALUOp;
            bus.EX_xfer_size      <= bus.ID_xfer_size;
            bus.EX_valid          <= ~bus.ID_NOOP;
        end
    end

    // Flush takes priority, so a cycle with both F and H bumps only flush_count.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.stall_count <= '0;
            bus.flush_count <= '0;
        end else if (flush) begin
            if (bus.flush_count != CNT_MAX)
                bus.flush_count <= bus.flush_count + CNT_ONE;
        end else if (hazard) begin
            if (bus.stall_count != CNT_MAX)
                bus.stall_count <= bus.stall_count + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_idex_pipe.sv
// Bench for idex_pipe: directed scenarios then random traffic, all checked
// against an instruction-level model of the EX slot and the two counters.
module tb_idex_pipe;
    localparam int DW = 64;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [63:0] pc, rega, regb, imm12, daddr9;
        logic [4:0]  rn, rm, rd;
        logic        usesrm;
        logic [5:0]  shamt;
        logic        regwrite, memwrite, memtoreg, brtaken, read_enable, noop, shiftdir;
        logic [1:0]  alusrc, aluresult;
        logic [2:0]  aluop;
        logic [3:0]  xfer;
        logic        valid;
    } ex_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    idex_pipe_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
    idex_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int   total = 0;
    int   bad   = 0;
    ex_t  exp_ex;
    int   exp_stall, exp_flush;
    logic last_stall, last_flush;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic ex_t bubble();
        ex_t t = '0;
        t.noop = 1'b1;
        return t;
    endfunction

    function automatic ex_t blank_id();
        ex_t t = '0;
        return t;
    endfunction

    function automatic logic [4:0] pick_reg();
        int r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    function automatic ex_t rand_id();
        ex_t t;
        t.pc = {$urandom, $urandom};       t.rega = {$urandom, $urandom};
        t.regb = {$urandom, $urandom};     t.imm12 = {$urandom, $urandom};
        t.daddr9 = {$urandom, $urandom};
        t.rn = pick_reg(); t.rm = pick_reg(); t.rd = pick_reg();
        t.usesrm = 1'($urandom_range(0, 1));
        t.shamt = 6'($urandom_range(0, 63));
        t.regwrite = 1'($urandom_range(0, 1)); t.memwrite = 1'($urandom_range(0, 1));
        t.memtoreg = 1'($urandom_range(0, 1)); t.brtaken = 1'($urandom_range(0, 1));
        t.read_enable = ($urandom_range(0, 2) == 0);
        t.noop = ($urandom_range(0, 7) == 0);
        t.shiftdir = 1'($urandom_range(0, 1));
        t.alusrc = 2'($urandom_range(0, 3)); t.aluresult = 2'($urandom_range(0, 3));
        t.aluop = 3'($urandom_range(0, 7)); t.xfer = 4'($urandom_range(0, 15));
        t.valid = 1'b0;
        return t;
    endfunction

    // Does the instruction sitting in EX load a register that the ID instruction reads?
    function automatic logic load_use(input ex_t ex, input ex_t id);
        logic is_load = ex.valid && ex.read_enable && (ex.rd != 5'd31);
        logic reads = (id.rn == ex.rd) || (id.usesrm && id.rm == ex.rd);
        return is_load && !id.noop && reads;
    endfunction

    function automatic ex_t get_ex();
        ex_t t;
        t.pc = bus.EX_PC; t.rega = bus.EX_RegA; t.regb = bus.EX_RegB;
        t.imm12 = bus.EX_Imm12Ext; t.daddr9 = bus.EX_DAddr9Ext;
        t.rn = bus.EX_Rn; t.rm = bus.EX_Rm; t.rd = bus.EX_Rd;
        t.usesrm = bus.EX_usesRm; t.shamt = bus.EX_shamt;
        t.regwrite = bus.EX_RegWrite; t.memwrite = bus.EX_MemWrite;
        t.memtoreg = bus.EX_MemToReg; t.brtaken = bus.EX_BrTaken;
        t.read_enable = bus.EX_read_enable; t.noop = bus.EX_NOOP;
        t.shiftdir = bus.EX_shiftDirection; t.alusrc = bus.EX_ALUSrc;
        t.aluresult = bus.EX_ALUResult; t.aluop = bus.EX_ALUOp;
        t.xfer = bus.EX_xfer_size; t.valid = bus.EX_valid;
        return t;
    endfunction

    task automatic drive(input ex_t id, input logic br, input logic rst);
        reset = rst;
        bus.ID_PC = id.pc; bus.ID_RegA = id.rega; bus.ID_RegB = id.regb;
        bus.ID_Imm12Ext = id.imm12; bus.ID_DAddr9Ext = id.daddr9;
        bus.ID_Rn = id.rn; bus.ID_Rm = id.rm; bus.ID_Rd = id.rd;
        bus.ID_usesRm = id.usesrm; bus.ID_shamt = id.shamt;
        bus.ID_RegWrite = id.regwrite; bus.ID_MemWrite = id.memwrite;
        bus.ID_MemToReg = id.memtoreg; bus.ID_BrTaken = id.brtaken;
        bus.ID_read_enable = id.read_enable; bus.ID_NOOP = id.noop;
        bus.ID_shiftDirection = id.shiftdir; bus.ID_ALUSrc = id.alusrc;
        bus.ID_ALUResult = id.aluresult; bus.ID_ALUOp = id.aluop;
        bus.ID_xfer_size = id.xfer; bus.EXMEM_BrTaken = br;
    endtask

    // One cycle: drive at negedge, check combinational outputs, clock, check EX state.
    task automatic step(input ex_t id, input logic br, input logic rst);
        logic h;
        drive(id, br, rst);
        #1;
        h = load_use(exp_ex, id);
        last_stall = bus.stall_IF;
        last_flush = bus.flush_IFID;
        chk("stall_IF", 512'(last_stall), 512'(h && !br));
        chk("flush_IFID", 512'(last_flush), 512'(br));
        @(posedge clk);
        if (rst) begin
            exp_ex = bubble(); exp_stall = 0; exp_flush = 0;
        end else if (br) begin
            exp_ex = bubble(); if (exp_flush < CMAX) exp_flush++;
        end else if (h) begin
            exp_ex = bubble(); if (exp_stall < CMAX) exp_stall++;
        end else begin
            exp_ex = id; exp_ex.valid = !id.noop;
        end
        #1;
        chk("ex_slot", 512'(get_ex()), 512'(exp_ex));
        chk("stall_count", 512'(bus.stall_count), 512'(exp_stall));
        chk("flush_count", 512'(bus.flush_count), 512'(exp_flush));
        @(negedge clk);
    endtask

    initial begin
        ex_t id, ld;
        exp_ex = bubble(); exp_stall = 0; exp_flush = 0;
        drive(rand_id(), 1'b0, 1'b1);
        @(posedge clk); @(negedge clk);

        // reset held with arbitrary inputs
        step(rand_id(), 1'b0, 1'b1);
        step(rand_id(), 1'b0, 1'b1);
        chk("rst_noop", 512'(bus.EX_NOOP), 512'(1));
        chk("rst_valid", 512'(bus.EX_valid), 512'(0));
        chk("rst_pc", 512'(bus.EX_PC), 512'(0));
        chk("rst_cnt", 512'(bus.flush_count), 512'(0));

        // passthrough
        id = blank_id(); id.pc = 64'h40; id.rega = 64'hDEAD; id.aluop = 3'b010; id.regwrite = 1'b1;
        step(id, 1'b0, 1'b0);
        chk("pt_pc", 512'(bus.EX_PC), 512'(64'h40));
        chk("pt_rega", 512'(bus.EX_RegA), 512'(64'hDEAD));
        chk("pt_aluop", 512'(bus.EX_ALUOp), 512'(3'b010));
        chk("pt_valid", 512'(bus.EX_valid), 512'(1));
        chk("pt_stall", 512'(last_stall), 512'(0));

        // load-use: LDUR X1 then ADD X3, X1, X2
        ld = blank_id(); ld.read_enable = 1'b1; ld.rd = 5'd1; ld.rn = 5'd5; ld.memtoreg = 1'b1;
        step(ld, 1'b0, 1'b0);
        id = blank_id(); id.rn = 5'd1; id.rm = 5'd2; id.usesrm = 1'b1; id.rd = 5'd3; id.regwrite = 1'b1;
        step(id, 1'b0, 1'b0);
        chk("lu_stall", 512'(last_stall), 512'(1));
        chk("lu_bubble", 512'(bus.EX_valid), 512'(0));
        chk("lu_scount", 512'(bus.stall_count), 512'(1));
        step(id, 1'b0, 1'b0);
        chk("lu_nostall2", 512'(last_stall), 512'(0));
        chk("lu_adv_rn", 512'(bus.EX_Rn), 512'(1));
        chk("lu_adv_valid", 512'(bus.EX_valid), 512'(1));

        // XZR destination never hazards
        ld.rd = 5'd31;
        step(ld, 1'b0, 1'b0);
        id = blank_id(); id.rn = 5'd31;
        step(id, 1'b0, 1'b0);
        chk("xzr_stall", 512'(last_stall), 512'(0));

        // Rm match but Rm unused
        ld.rd = 5'd2;
        step(ld, 1'b0, 1'b0);
        id = blank_id(); id.rn = 5'd7; id.rm = 5'd2; id.usesrm = 1'b0;
        step(id, 1'b0, 1'b0);
        chk("rm_unused_stall", 512'(last_stall), 512'(0));

        // flush beats stall
        step(rand_id(), 1'b0, 1'b1);
        ld.rd = 5'd4;
        step(ld, 1'b0, 1'b0);
        id = blank_id(); id.rn = 5'd4;
        step(id, 1'b1, 1'b0);
        chk("fb_stall", 512'(last_stall), 512'(0));
        chk("fb_flush", 512'(last_flush), 512'(1));
        chk("fb_fcount", 512'(bus.flush_count), 512'(1));
        chk("fb_scount", 512'(bus.stall_count), 512'(0));
        chk("fb_valid", 512'(bus.EX_valid), 512'(0));

        // flush counter saturation: 2^CW + 3 flush cycles after a reset
        step(rand_id(), 1'b0, 1'b1);
        for (int i = 0; i < (1 << CW) + 3; i++) step(rand_id(), 1'b1, 1'b0);
        chk("sat_flush", 512'(bus.flush_count), 512'(15));

        // reset mid-stall suppresses the stall increment
        step(rand_id(), 1'b0, 1'b1);
        ld.rd = 5'd3;
        step(ld, 1'b0, 1'b0);
        id = blank_id(); id.rn = 5'd3;
        step(id, 1'b0, 1'b1);
        chk("rst_mid_scount", 512'(bus.stall_count), 512'(0));

        // random traffic
        for (int i = 0; i < 400; i++)
            step(rand_id(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/idex_pipe.md
# idex_pipe

ID/EX pipeline boundary of the five-stage 64-bit CPU. It sits directly downstream of the decode stage and control unit, and directly upstream of execute. It registers every decoded operand and control signal for execute. It also performs load-use hazard detection, producing the stall that freezes PC and IF/ID, and inserts bubbles on load-use stalls and taken-branch flushes. Two saturating performance counters track stall and flush cycles.

## Interface
- DATA_WIDTH, 64, width of PC, register operands and extended immediates
- CNT_WIDTH, 32, width of each performance counter

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- ID_PC, ID_RegA, ID_RegB, ID_Imm12Ext, ID_DAddr9Ext  in  DATA_WIDTH  decoded PC, operands, extended immediates
- ID_Rn, ID_Rm, ID_Rd  in  5  register specifiers
- ID_usesRm  in  1  instruction reads Rm as a source (R-type ALU, STUR data)
- ID_shamt  in  6  shift amount
- ID_RegWrite, ID_MemWrite, ID_MemToReg, ID_BrTaken, ID_read_enable, ID_NOOP, ID_shiftDirection  in  1  control
- ID_ALUSrc, ID_ALUResult  in  2;  ID_ALUOp  in  3;  ID_xfer_size  in  4  control
- EXMEM_BrTaken  in  1  taken branch resolved downstream; flush request
- EX_* (one output per ID_* input above, same width)  out  registered copy for execute
- EX_valid  out  1  EX slot holds a real instruction
- stall_IF  out  1  combinational; hold PC and IF/ID this cycle
- flush_IFID  out  1  combinational; convert IF/ID contents to NOOP at next edge
- stall_count, flush_count  out  CNT_WIDTH  saturating event counters

## Operation
- Hazard condition H, evaluated combinationally:
  - EX_valid & EX_read_enable & (EX_Rd != 31)
  - & ~ID_NOOP
  - & (EX_Rd == ID_Rn | (ID_usesRm & EX_Rd == ID_Rm))
- X31 (XZR) never creates a hazard.
- Flush condition F = EXMEM_BrTaken.
- Per-edge action, in priority order:
  - reset: bubble; counters to 0.
  - F: bubble; flush_count +1.
  - H: bubble; stall_count +1.
  - otherwise: load all EX_* from ID_*; EX_valid = ~ID_NOOP.
- Bubble:
  - EX_RegWrite, EX_MemWrite, EX_MemToReg, EX_BrTaken, EX_read_enable = 0.
  - EX_NOOP = 1; EX_valid = 0.
  - All data, specifier and other control fields = 0.
- Output gating:
  - stall_IF = H & ~F. A flush overrides the stall, since the stalled instruction is discarded.
  - flush_IFID = F.
- Counters saturate at 2^CNT_WIDTH−1; they never wrap.
- Reset value of every output: EX_NOOP = 1; all other EX_* = 0; EX_valid = 0; counters = 0. stall_IF and flush_IFID = 0 whenever EX holds a bubble and EXMEM_BrTaken = 0.

## Timing
- Latency: ID inputs appear on EX_* one edge after capture.
- Load-use costs exactly one bubble. The cycle after a stall, EX holds the bubble (EX_read_enable = 0), so H deasserts and the held instruction advances on the following edge.
- Back-to-back loads into a dependent consumer stall once per dependent pair, never twice.
- F and H in the same cycle: one bubble; flush_count +1; stall_count unchanged; stall_IF = 0.
- Reset asserted mid-stall or mid-flush: next edge yields the reset state. Counter increments are suppressed for that edge.
- stall_IF and flush_IFID depend only on current registered EX state plus same-cycle ID/EXMEM inputs. There is no combinational path from EX_* outputs back to ID_* inputs inside the block.

## Test plan
- Reset: hold reset 2 cycles with arbitrary ID inputs → EX_NOOP = 1, EX_valid = 0, all other EX_* = 0, counters = 0, stall_IF = 0.
- Passthrough: ID_PC = 0x40, ID_RegA = 0xDEAD, ID_ALUOp = 3'b010, ID_RegWrite = 1 → next edge EX_PC = 0x40, EX_RegA = 0xDEAD, EX_ALUOp = 3'b010, EX_valid = 1, no stall.
- Load-use: LDUR X1 in EX (read_enable = 1, Rd = 1); ADD with ID_Rn = 1 in ID → stall_IF = 1 for one cycle, one bubble, stall_count = 1. The ADD reaches EX on the second edge.
- XZR and unused Rm:
  - LDUR X31 in EX with ID_Rn = 31 → no stall.
  - LDUR X2 in EX, ID_Rm = 2, ID_usesRm = 0 → no stall.
- Flush beats stall: hazard present and EXMEM_BrTaken = 1 → stall_IF = 0, flush_IFID = 1, bubble, flush_count = 1, stall_count = 0.
- Saturation: force 2^CNT_WIDTH+3 flush cycles (CNT_WIDTH reduced to 4 in the bench) → flush_count holds at 15.
